usb_in_arbiter: RTL

Packetizes and schedules byte streams from two on-chip requesters onto one bulk IN endpoint of the USB full-speed device core. The block sits between the byte producers (e.g. the annunciator and a second status source) and the core's transaction interface. It collects one packet at a time from a round-robin-granted requester into a local buffer. It replays that packet until the host acknowledges it, so no byte is lost on a failed IN transaction.

---
 rtl/usb_in_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/usb_in_arbiter.sv
// usb_in_arbiter: takes one packet at a time from two round-robin requesters
// into a local buffer and replays it on a bulk IN endpoint until the host ACKs it.
module usb_in_arbiter #(
    parameter logic [3:0] EP           = 4'd1,
    parameter int         MAX_PKT      = 8,
    parameter int         FLUSH_CYCLES = 4800
) (
    input  logic        clk48,
    input  logic        rst,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic        usb_rst,
    input  logic        transaction_active,
    input  logic [3:0]  endpoint,
    input  logic        direction_in,
    input  logic        setup,
    input  logic        data_strobe,
    input  logic        success,
    output logic        in_pkt_ready,
    output logic [7:0]  in_data,
    output logic        in_valid,
    output logic        grant
);
    localparam int CW = $clog2(MAX_PKT) + 1;
    localparam int AW = CW - 1;
    localparam int TW = $clog2(FLUSH_CYCLES);
    localparam logic [CW-1:0] FULL  = CW'(MAX_PKT);
    localparam logic [TW-1:0] TLAST = TW'(FLUSH_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] READY = 2'd2;
    localparam logic [1:0] SEND  = 2'd3;

    logic [1:0]    state;
    logic          prio;
    logic          ack;
    logic          match_d;
    logic [CW-1:0] count;
    logic [CW-1:0] rd;
    logic [TW-1:0] timer;
    logic [7:0]    pkt_buf [MAX_PKT];

    logic       match;
    logic       has_room;
    logic       accept;
    logic [7:0] sel_data;

    assign match     = transaction_active && (endpoint == EP) && direction_in && !setup;
    assign has_room  = (state == FILL) && (count < FULL);
    assign req_ready = has_room ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = has_room && req_valid[grant];
    assign sel_data  = grant ? req_data[15:8] : req_data[7:0];
    assign in_valid  = (state == SEND) && (rd < count);
    assign in_data   = in_valid ? pkt_buf[rd[AW-1:0]] : 8'h00;

    // The packet buffer needs no reset: it is only read below count.
    always_ff @(posedge clk48) begin
        if (accept) begin
            pkt_buf[count[AW-1:0]] <= sel_data;
        end
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            prio         <= 1'b0;
            ack          <= 1'b0;
            match_d      <= 1'b0;
            count        <= '0;
            rd           <= '0;
            timer        <= '0;
            in_pkt_ready <= 1'b0;
        end else if (usb_rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            prio         <= 1'b0;
            ack          <= 1'b0;
            match_d      <= 1'b0;
            count        <= '0;
            rd           <= '0;
            timer        <= '0;
            in_pkt_ready <= 1'b0;
        end else begin
            match_d <= match;
            case (state)
                IDLE: begin
                    if (req_valid[prio]) begin
                        grant <= prio;
                        state <= FILL;
                        count <= '0;
                        timer <= '0;
                    end else if (req_valid[!prio]) begin
                        grant <= !prio;
                        state <= FILL;
                        count <= '0;
                        timer <= '0;
                    end
                end
                FILL: begin
                    // The flush timer only runs once a partial packet exists.
                    if (count == FULL) begin
                        state        <= READY;
                        in_pkt_ready <= 1'b1;
                    end else if (accept) begin
                        count <= count + 1'b1;
                        timer <= '0;
                    end else if (count != '0) begin
                        if (timer == TLAST) begin
                            state        <= READY;
                            in_pkt_ready <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                READY: begin
                    rd  <= '0;
                    ack <= 1'b0;
                    if (match && !match_d) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (match && data_strobe && (rd < count)) begin
                        rd <= rd + 1'b1;
                    end
                    if (match && success) begin
                        ack <= 1'b1;
                    end
                    // End of transaction: free the buffer on ACK, otherwise replay.
                    if (!transaction_active) begin
                        ack <= 1'b0;
                        if (ack) begin
                            prio         <= !grant;
                            count        <= '0;
                            state        <= IDLE;
                            in_pkt_ready <= 1'b0;
                        end else begin
                            rd    <= '0;
                            state <= READY;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
